fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: a PC, a single-cycle synchronous imem port and a DEPTH-entry instruction FIFO.

---
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, single-cycle synchronous imem port and a DEPTH-entry FIFO.
// Define FETCH_QUEUE_PC_EN to add pc_o, the word address of the FIFO head entry.
module fetch_queue #(
    parameter int WORD  = 32,
    parameter int ADDR  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ADDR-1:0] next_addr,
    output logic            imem_req,
    input  logic [WORD-1:0] inst_i,
    output logic [WORD-1:0] inst_o,
    output logic            v_o,
    input  logic            stall_i,
    output logic            stall_o,
    input  logic            branch,
`ifdef FETCH_QUEUE_PC_EN
    input  logic [ADDR-1:0] branch_addr,
    output logic [ADDR-1:0] pc_o
`else
    input  logic [ADDR-1:0] branch_addr
`endif
);

    localparam int PTRW = $clog2(DEPTH);

    // Handshake: inst_o is consumed in a cycle where v_o=1 and stall_i=0 and branch=0;
    // imem data is taken unconditionally the cycle after imem_req.
    logic [PTRW:0]   count;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic            inflight;
    logic [ADDR-1:0] pc_r;
    logic [WORD-1:0] inst_mem [DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [PTRW+1:0] credit;

    assign v_o  = (count != '0);
    assign pop  = v_o & ~stall_i & ~branch;
    assign push = inflight & ~branch;

    // Credits count queued plus in-flight words, so a returning word always has a slot.
    assign credit = {1'b0, count} + (PTRW+2)'(inflight) - (PTRW+2)'(pop);
    assign issue  = ~branch & (credit < (PTRW+2)'(DEPTH));

    assign imem_req  = issue;
    assign stall_o   = ~issue & ~branch;
    assign next_addr = pc_r;
    assign inst_o    = inst_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else if (branch) begin
            // Flush: queue emptied, returning word dropped, fetch restarts at the target.
            count    <= '0;
            rd_ptr   <= wr_ptr;
            inflight <= 1'b0;
            pc_r     <= branch_addr;
        end else begin
            inflight <= issue;
            if (issue) pc_r <= pc_r + ADDR'(1);
            if (push)  wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)   rd_ptr <= rd_ptr + PTRW'(1);
            count <= count + (PTRW+1)'(push) - (PTRW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) inst_mem[wr_ptr] <= inst_i;
    end

`ifdef FETCH_QUEUE_PC_EN
    logic [ADDR-1:0] pc_mem [DEPTH];
    logic [ADDR-1:0] inflight_pc;

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= pc_r;
        if (push)  pc_mem[wr_ptr] <= inflight_pc;
    end

    assign pc_o = pc_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a synchronous imem model holding 0x1000_0000 + address.
// Define FETCH_QUEUE_PC_EN to also check pc_o.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] next_addr;
    logic        imem_req;
    logic [31:0] inst_i;
    logic [31:0] inst_o;
    logic        v_o;
    logic        stall_i;
    logic        stall_o;
    logic        branch;
    logic [15:0] branch_addr;
`ifdef FETCH_QUEUE_PC_EN
    logic [15:0] pc_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.WORD(32), .ADDR(16), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_addr   (next_addr),
        .imem_req    (imem_req),
        .inst_i      (inst_i),
        .inst_o      (inst_o),
        .v_o         (v_o),
        .stall_i     (stall_i),
        .stall_o     (stall_o),
        .branch      (branch),
`ifdef FETCH_QUEUE_PC_EN
        .branch_addr (branch_addr),
        .pc_o        (pc_o)
`else
        .branch_addr (branch_addr)
`endif
    );

    // Synchronous instruction memory: data for address A is 0x1000_0000 + A.
    always @(posedge clk) begin
        if (imem_req) inst_i <= 32'h1000_0000 + {16'h0000, next_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units into cycle 0, the first cycle after reset release.
    task automatic apply_reset(input logic stall);
        tick();
        reset   = 1'b1;
        branch  = 1'b0;
        stall_i = stall;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_i = 1'b0; branch = 1'b0; branch_addr = '0;
        #2;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL rst_v_o: got %b want 0", v_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall_o: got %b want 0", stall_o); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_imem_req: got %b want 1", imem_req); end
        total++; if (next_addr !== 16'h0000) begin bad++; $display("FAIL rst_next_addr: got %h want 0000", next_addr); end
        apply_reset(1'b0);
    endtask

    // Continues from cycle 0 left by test_reset.
    task automatic test_stream();
        total++; if (imem_req !== 1'b1 || next_addr !== 16'h0000) begin
            bad++; $display("FAIL stream_c0_req: got req=%b addr=%h want req=1 addr=0000", imem_req, next_addr); end
        tick(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL stream_c1_v_o: got %b want 0", v_o); end
        for (int k = 2; k < 10; k++) begin
            tick(); #1;
            total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0000 + 32'(k - 2)) begin
                bad++; $display("FAIL stream_c%0d: got v=%b inst=%h want v=1 inst=%h", k, v_o, inst_o, 32'h1000_0000 + 32'(k - 2)); end
`ifdef FETCH_QUEUE_PC_EN
            total++; if (pc_o !== 16'(k - 2)) begin
                bad++; $display("FAIL stream_pc_c%0d: got %h want %h", k, pc_o, 16'(k - 2)); end
`endif
        end
    endtask

    task automatic test_stall_fill();
        apply_reset(1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick(); #1;
            if (k == 4) begin
                total++; if (stall_o !== 1'b1 || imem_req !== 1'b0 || next_addr !== 16'h0004) begin
                    bad++; $display("FAIL fill_c4: got stall_o=%b req=%b addr=%h want 1 0 0004", stall_o, imem_req, next_addr); end
            end
        end
        total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0000) begin
            bad++; $display("FAIL fill_head: got v=%b inst=%h want v=1 inst=10000000", v_o, inst_o); end
        total++; if (stall_o !== 1'b1 || imem_req !== 1'b0 || next_addr !== 16'h0004) begin
            bad++; $display("FAIL fill_full: got stall_o=%b req=%b addr=%h want 1 0 0004", stall_o, imem_req, next_addr); end
        for (int k = 0; k < 6; k++) begin
            tick();
            stall_i = 1'b0;
            #1;
            total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0000 + 32'(k)) begin
                bad++; $display("FAIL drain_%0d: got v=%b inst=%h want v=1 inst=%h", k, v_o, inst_o, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_branch_full();
        apply_reset(1'b1);
        for (int k = 1; k <= 5; k++) tick();
        tick();
        branch = 1'b1; branch_addr = 16'h0200;
        #1;
        total++; if (imem_req !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL brf_cb: got req=%b stall_o=%b want 0 0", imem_req, stall_o); end
        tick();
        branch = 1'b0; stall_i = 1'b0;
        #1;
        total++; if (v_o !== 1'b0 || next_addr !== 16'h0200 || imem_req !== 1'b1) begin
            bad++; $display("FAIL brf_cb1: got v=%b addr=%h req=%b want 0 0200 1", v_o, next_addr, imem_req); end
        tick(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL brf_cb2: got v=%b want 0", v_o); end
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0200 + 32'(k)) begin
                bad++; $display("FAIL brf_seq%0d: got v=%b inst=%h want v=1 inst=%h", k, v_o, inst_o, 32'h1000_0200 + 32'(k)); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b0);
        for (int k = 1; k <= 3; k++) tick();
        tick();
        branch = 1'b1; branch_addr = 16'h0100;
        tick();
        branch = 1'b1; branch_addr = 16'h0300;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL b2b_cb1: got v=%b want 0", v_o); end
        tick();
        branch = 1'b0;
        #1;
        total++; if (v_o !== 1'b0 || next_addr !== 16'h0300 || imem_req !== 1'b1) begin
            bad++; $display("FAIL b2b_cb2: got v=%b addr=%h req=%b want 0 0300 1", v_o, next_addr, imem_req); end
        tick(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL b2b_cb3: got v=%b want 0", v_o); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0300 + 32'(k)) begin
                bad++; $display("FAIL b2b_seq%0d: got v=%b inst=%h want v=1 inst=%h", k, v_o, inst_o, 32'h1000_0300 + 32'(k)); end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_inst [3];
        logic [15:0] exp_pc [3];
        exp_inst[0] = 32'h1000_FFFE; exp_inst[1] = 32'h1000_FFFF; exp_inst[2] = 32'h1000_0000;
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
        apply_reset(1'b0);
        tick();
        branch = 1'b1; branch_addr = 16'hFFFE;
        tick();
        branch = 1'b0;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL wrap_cb1: got v=%b want 0", v_o); end
        tick(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL wrap_cb2: got v=%b want 0", v_o); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            total++; if (v_o !== 1'b1 || inst_o !== exp_inst[k]) begin
                bad++; $display("FAIL wrap_seq%0d: got v=%b inst=%h want v=1 inst=%h", k, v_o, inst_o, exp_inst[k]); end
`ifdef FETCH_QUEUE_PC_EN
            total++; if (pc_o !== exp_pc[k]) begin
                bad++; $display("FAIL wrap_pc%0d: got %h want %h", k, pc_o, exp_pc[k]); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        for (int k = 1; k <= 4; k++) tick();
        #1;
        total++; if (v_o !== 1'b1 || stall_o !== 1'b1) begin
            bad++; $display("FAIL mid_pre: got v=%b stall_o=%b want 1 1", v_o, stall_o); end
        reset = 1'b1;
        #1;
        total++; if (v_o !== 1'b0 || stall_o !== 1'b0 || next_addr !== 16'h0000) begin
            bad++; $display("FAIL mid_async: got v=%b stall_o=%b addr=%h want 0 0 0000", v_o, stall_o, next_addr); end
        tick();
        reset = 1'b0; stall_i = 1'b0;
        tick(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL mid_c1: got v=%b want 0", v_o); end
        tick(); #1;
        total++; if (v_o !== 1'b1 || inst_o !== 32'h1000_0000) begin
            bad++; $display("FAIL mid_c2: got v=%b inst=%h want v=1 inst=10000000", v_o, inst_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_branch_full();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
